// File: rtl/index_pixel_timer.sv
// Rotor period tracker: conditions the encoder index, measures the revolution
// period and paces one pixel_tick per column at period / PIXELS_PER_REV.
module index_pixel_timer #(
    parameter int PIXELS_PER_REV     = 128,
    parameter int CNT_W              = 28,
    parameter int DEBOUNCE           = 1000,
    parameter int MIN_PERIOD         = 100000,
    parameter int TIMEOUT            = 100000000,
    parameter int DEFAULT_PIXEL_CLKS = 500000,
    localparam int IDX_W = (PIXELS_PER_REV > 1) ? $clog2(PIXELS_PER_REV) : 1
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             index_n,
    output logic             frame_start,
    output logic             pixel_tick,
    output logic [IDX_W-1:0] pixel_index,
    output logic [CNT_W-1:0] rev_period,
    output logic             locked,
    output logic             stalled,
    output logic [1:0]       track_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } track_state_e;

    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam int DC_W  = $clog2(CNT_W + 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_PERIOD - 1);
    localparam logic [CNT_W-1:0] DEFAULT_C = CNT_W'(DEFAULT_PIXEL_CLKS);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W:0]   DIVISOR   = (CNT_W + 1)'(PIXELS_PER_REV);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PIXELS_PER_REV - 1);

    logic [1:0]       sync_q;
    logic             deb_level;
    logic             deb_prev;
    logic [DEB_W-1:0] deb_cnt;
    logic             index_ev;

    track_state_e     state_q;
    track_state_e     state_d;
    logic             accept;
    logic             measure_ok;
    logic             stall;
    logic             dist_ok;
    logic [CNT_W-1:0] period_cnt;

    logic             div_busy;
    logic             div_wr;
    logic [DC_W-1:0]  div_cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_r;
    logic [CNT_W:0]   div_shift;
    logic             div_ge;
    logic [CNT_W-1:0] div_diff;
    logic [CNT_W-1:0] pixel_clks;

    logic [CNT_W-1:0] active_clks;
    logic [CNT_W-1:0] pix_cnt;
    logic             pix_run;
    logic [IDX_W-1:0] next_idx;

    // Index conditioning; the event fires one cycle after the debounced fall.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            deb_level <= 1'b1;
            deb_prev  <= 1'b1;
            deb_cnt   <= '0;
            index_ev  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], index_n};
            deb_prev <= deb_level;
            index_ev <= deb_prev & ~deb_level;
            if (sync_q[1] != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= sync_q[1];
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign dist_ok = (period_cnt >= MIN_LAST);

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        measure_ok = 1'b0;
        stall      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (index_ev) begin
                    accept  = 1'b1;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (index_ev && dist_ok) begin
                    accept     = 1'b1;
                    measure_ok = 1'b1;
                    state_d    = ST_LOCKED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // An accepted event in the saturation cycle suppresses the stall.
        if (!accept && period_cnt == TO_LAST) begin
            stall   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            period_cnt  <= '0;
            rev_period  <= '0;
            stalled     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_start <= accept;
            if (accept) begin
                period_cnt <= '0;
            end else if (period_cnt != TIMEOUT_C) begin
                period_cnt <= period_cnt + ONE;
            end
            if (measure_ok) begin
                rev_period <= period_cnt + ONE;
            end
            if (accept) begin
                stalled <= 1'b0;
            end else if (stall) begin
                stalled <= 1'b1;
            end
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign track_state = state_q;

    // Restoring divider, one quotient bit per cycle, MSB first.
    assign div_shift = {div_r, div_q[CNT_W-1]};
    assign div_ge    = (div_shift >= DIVISOR);
    assign div_diff  = CNT_W'(div_shift - DIVISOR);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy   <= 1'b0;
            div_wr     <= 1'b0;
            div_cnt    <= '0;
            div_q      <= '0;
            div_r      <= '0;
            pixel_clks <= DEFAULT_C;
        end else begin
            div_wr <= 1'b0;
            if (measure_ok) begin
                div_busy <= 1'b1;
                div_cnt  <= DC_W'(CNT_W);
                div_q    <= period_cnt + ONE;
                div_r    <= '0;
            end else if (div_busy) begin
                div_q   <= {div_q[CNT_W-2:0], div_ge};
                div_r   <= div_ge ? div_diff : div_shift[CNT_W-1:0];
                div_cnt <= div_cnt - DC_W'(1);
                if (div_cnt == DC_W'(1)) begin
                    div_busy <= 1'b0;
                    div_wr   <= 1'b1;
                end
            end
            if (div_wr) begin
                pixel_clks <= (div_q == '0) ? ONE : div_q;
            end
        end
    end

    assign next_idx = pixel_index + IDX_W'(1);

    // Pixel generator: a frame runs once through all columns and then waits.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_tick  <= 1'b0;
            pixel_index <= '0;
            active_clks <= '0;
            pix_cnt     <= '0;
            pix_run     <= 1'b0;
        end else begin
            pixel_tick <= 1'b0;
            if (accept) begin
                pixel_tick  <= 1'b1;
                pixel_index <= '0;
                active_clks <= pixel_clks;
                pix_cnt     <= '0;
                pix_run     <= (PIXELS_PER_REV > 1);
            end else if (stall) begin
                pix_run <= 1'b0;
            end else if (pix_run) begin
                if (pix_cnt == active_clks - ONE) begin
                    pixel_tick  <= 1'b1;
                    pixel_index <= next_idx;
                    pix_cnt     <= '0;
                    if (next_idx == LAST_IDX) begin
                        pix_run <= 1'b0;
                    end
                end else begin
                    pix_cnt <= pix_cnt + ONE;
                end
            end
        end
    end

endmodule
